// File: rtl/timestamp_capture_feeder.sv
// Free-running sample timestamp with snapshot capture and ready/enable hand-off to a CDC synchroniser.
// Optional TIMESTAMP_CAPTURE_DROP_COUNT_EN adds a saturating dropped-capture counter port.
module timestamp_capture_feeder #(
  parameter int TS_WIDTH       = 64,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      sample_valid,
  input  logic                      capture,
  input  logic                      cdc_ready,
  output logic                      cdc_enable,
  output logic [TS_WIDTH-1:0]       cdc_data,
  output logic [TS_WIDTH-1:0]       timestamp,
  output logic                      overflow,
  input  logic                      clear_overflow
`ifdef TIMESTAMP_CAPTURE_DROP_COUNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [TS_WIDTH-1:0] ts;
  logic                load;
  logic                drop;

  assign timestamp  = ts;
  assign cdc_enable = (state_q == PENDING);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A completing edge with a fresh capture reloads instead of dropping.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (cdc_ready) begin
          if (capture) load    = 1'b1;
          else         state_d = IDLE;
        end else if (capture) begin
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts       <= '0;
      cdc_data <= '0;
    end else begin
      if (sample_valid) ts       <= ts + TS_WIDTH'(1);
      if (load)         cdc_data <= ts;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

`ifdef TIMESTAMP_CAPTURE_DROP_COUNT_EN
  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop) begin
      if (clear_overflow)       drop_count <= DROP_CNT_WIDTH'(1);
      else if (drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end else if (clear_overflow) begin
      drop_count <= '0;
    end
  end
`endif

endmodule
